pb_conditioner: RTL and testbench

- Dual-channel push-button front end for the tug-of-war game.
- Synchronizes and debounces the raw left/right buttons. Emits one-cycle press pulses into the button-arbitration stage that decides round winner, direction and tie.
- Sits directly upstream of that stage and runs on the 500 Hz divided game clock.
- Honours a lock input so presses made while a round is resolving are discarded.

---
 rtl/pb_conditioner.sv | 130 +++++++++++++
 tb/tb_pb_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pb_conditioner.sv
// Two-channel button synchronizer/debouncer emitting one-cycle press pulses, 3+DEB_CYCLES edges after a raw rise.
// Pulses are masked and rises dropped while lock=1; define TIE_DETECT_EN to hold presses TIE_WINDOW cycles and merge near-simultaneous ones into tie.
module pb_conditioner #(
    parameter int DEB_CYCLES = 5,
    parameter int CNT_W      = 4,
    parameter int TIE_WINDOW = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl_raw,
    input  logic pbr_raw,
    input  logic lock,
    output logic pbl,
    output logic pbr,
    output logic pbl_level,
    output logic pbr_level,
    output logic tie
);

    if (DEB_CYCLES < 1 || DEB_CYCLES > (2**CNT_W) - 1 || TIE_WINDOW < 1 || TIE_WINDOW > 7) begin : g_param_err
        $error("pb_conditioner: parameter out of legal range");
    end

    // Channel index 0 = left, 1 = right throughout.
    logic [1:0]       w_raw;
    logic [1:0]       w_rise;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_stable;
    logic [1:0]       r_prev;
    logic [1:0]       r_pulse;
    logic [CNT_W-1:0] r_cnt [2];

    assign w_raw  = {pbr_raw, pbl_raw};
    assign w_rise = r_stable & ~r_prev & {2{~lock}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_prev <= r_stable;
        end
    end

    // Stable flips only after s2 has disagreed with it on DEB_CYCLES consecutive edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else if (r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef TIE_DETECT_EN
    logic       r_active;
    logic       r_tie;
    logic [1:0] r_pend;
    logic [2:0] r_win;

    // The first rise opens a window; a rise of the other channel up to and including the closing edge makes it a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_tie    <= 1'b0;
            r_pend   <= '0;
            r_win    <= '0;
            r_pulse  <= '0;
        end else begin
            r_pulse <= '0;
            r_tie   <= 1'b0;
            if (lock) begin
                r_active <= 1'b0;
                r_pend   <= '0;
                r_win    <= '0;
            end else if (r_active) begin
                if (r_win == 3'(TIE_WINDOW - 1)) begin
                    r_active <= 1'b0;
                    r_pend   <= '0;
                    r_win    <= '0;
                    if (&(r_pend | w_rise)) begin
                        r_tie <= 1'b1;
                    end else begin
                        r_pulse <= r_pend | w_rise;
                    end
                end else begin
                    r_win  <= r_win + 3'd1;
                    r_pend <= r_pend | w_rise;
                end
            end else if (|w_rise) begin
                r_active <= 1'b1;
                r_pend   <= w_rise;
                r_win    <= '0;
            end
        end
    end

    assign tie = r_tie & ~lock;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_rise;
        end
    end

    assign tie = 1'b0;
`endif

    assign pbl       = r_pulse[0] & ~lock;
    assign pbr       = r_pulse[1] & ~lock;
    assign pbl_level = r_stable[0];
    assign pbr_level = r_stable[1];

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed button scenarios with literal expectations, then randomized bouncy input checked every cycle against a history-based model.
module tb_pb_conditioner;

    localparam int DEB  = 5;
    localparam int HW   = 16;
    localparam logic [HW-1:0] MASK = HW'((1 << DEB) - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pbl_raw = 1'b0;
    logic pbr_raw = 1'b0;
    logic lock = 1'b0;
    logic pbl, pbr, pbl_level, pbr_level, tie;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pb_conditioner #(
        .DEB_CYCLES(DEB),
        .CNT_W(4),
        .TIE_WINDOW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pbl_raw(pbl_raw),
        .pbr_raw(pbr_raw),
        .lock(lock),
        .pbl(pbl),
        .pbr(pbr),
        .pbl_level(pbl_level),
        .pbr_level(pbr_level),
        .tie(tie)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sync is a two-deep delay; stable takes the s2 value once the last
    // DEB s2 samples (since reset or the last flip) all disagree with it.
    logic          m_s1   [2];
    logic          m_s2   [2];
    logic          m_st   [2];
    logic          m_st_d [2];
    logic          m_preg [2];
    logic [HW-1:0] m_hist [2];
    int            m_nval [2];

    task model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_st[c] = 1'b0;
            m_st_d[c] = 1'b0; m_preg[c] = 1'b0;
            m_hist[c] = '0; m_nval[c] = 0;
        end
    endtask

    task model_step();
        logic raw [2];
        logic s2p;
        raw[0] = pbl_raw;
        raw[1] = pbr_raw;
        for (int c = 0; c < 2; c++) begin
            s2p = m_s2[c];
            m_preg[c] = m_st[c] & ~m_st_d[c] & ~lock;
            m_st_d[c] = m_st[c];
            m_hist[c] = {m_hist[c][HW-2:0], s2p};
            if (m_nval[c] < HW) m_nval[c]++;
            if (m_nval[c] >= DEB && ((m_hist[c] ^ {HW{m_st[c]}}) & MASK) == MASK) begin
                m_st[c]   = s2p;
                m_nval[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
        end
    endtask

    // Every cycle: advance the model at the edge, compare 2 time units later.
    always begin
        @(posedge clk);
        if (rst) model_step();
        #2;
        if (!rst) model_reset();
        chk("model_level_l", pbl_level, m_st[0]);
        chk("model_level_r", pbr_level, m_st[1]);
        chk("model_pulse_l", pbl, m_preg[0] & ~lock);
        chk("model_pulse_r", pbr, m_preg[1] & ~lock);
        chk("model_tie", tie, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt;
    int hold_l, hold_r;

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (3) tick();
        #2;
        chk("rst_level_l", pbl_level, 1'b0);
        chk("rst_pulse_l", pbl, 1'b0);
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // Clean left press: level after edge 7, single pulse after edge 8.
        pbl_raw = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            #2;
            chk($sformatf("press_level_e%0d", e), pbl_level, (e >= 7));
            chk($sformatf("press_pulse_e%0d", e), pbl, (e == 8));
        end
        pbl_raw = 1'b0;
        repeat (12) tick();

        // Short right-button glitches never get through.
        for (int r = 0; r < 2; r++) begin
            pbr_raw = 1'b1;
            repeat (3) begin tick(); #2; chk("glitch_level_r", pbr_level, 1'b0); chk("glitch_pulse_r", pbr, 1'b0); end
            pbr_raw = 1'b0;
            repeat (3) begin tick(); #2; chk("glitch_level_r", pbr_level, 1'b0); chk("glitch_pulse_r", pbr, 1'b0); end
        end
        repeat (6) begin tick(); #2; chk("glitch_tail_r", pbr_level, 1'b0); end

        // Press under lock is discarded even after unlock while held.
        lock = 1'b1;
        pbl_raw = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15) lock = 1'b0;
            #2;
            chk("lock_pulse_l", pbl, 1'b0);
        end
        chk("lock_level_l", pbl_level, 1'b1);
        pbl_raw = 1'b0;
        repeat (12) tick();
        pbl_raw = 1'b1;
        cnt = 0;
        repeat (14) begin tick(); #2; if (pbl) cnt++; end
        chk_int("lock_repress_count", cnt, 1);
        pbl_raw = 1'b0;
        repeat (12) tick();

        // Simultaneous presses pulse together on edge 8.
        pbl_raw = 1'b1;
        pbr_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            #2;
            chk($sformatf("both_pulse_l_e%0d", e), pbl, (e == 8));
            chk($sformatf("both_pulse_r_e%0d", e), pbr, (e == 8));
        end
        pbl_raw = 1'b0;
        pbr_raw = 1'b0;
        repeat (12) tick();

        // Reset mid-debounce with button held: fresh debounce after release.
        pbl_raw = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        #2;
        chk("midrst_level_l", pbl_level, 1'b0);
        chk("midrst_pulse_l", pbl, 1'b0);
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            #2;
            chk($sformatf("midrst_level_e%0d", e), pbl_level, (e >= 7));
            chk($sformatf("midrst_pulse_e%0d", e), pbl, (e == 8));
        end

        // Random bouncy buttons, occasional lock and reset, against the model.
        hold_l = 0;
        hold_r = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst = 1'b0;
            if (hold_l == 0) begin pbl_raw = 1'($urandom_range(0, 1)); hold_l = $urandom_range(1, 12); end
            else hold_l--;
            if (hold_r == 0) begin pbr_raw = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 12); end
            else hold_r--;
            if ($urandom_range(0, 19) == 0) lock = ~lock;
        end
        tick();
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
